alu_mul_sequencer: RTL and testbench

- Multi-cycle unsigned shift-and-add multiplier that drives the shared combinational execute ALU.
- Returns the low 32 bits of the product; the result is identical for signed operands.
- Sits beside the ALU in the execute stage and owns the ALU operand/uop inputs while busy.
- Uses only the ALU ADD uop. Shifts are done locally so the ALU is used exactly once per iteration.

---
 rtl/alu_mul_sequencer.sv | 153 +++++++++++++++
 tb/tb_alu_mul_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle shift-and-add multiplier that borrows the execute ALU adder.
// Each RUN cycle issues one ADD and retires one multiplier bit, stopping at the highest set bit.
module alu_mul_sequencer #(
  parameter int unsigned W       = 32,
  parameter logic [4:0]  UOP_ADD = 5'b00001,
  parameter logic [4:0]  UOP_NOP = 5'b00000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         res_z,
  output logic         res_n,
  output logic         res_ovf,
  output logic [W-1:0] alu_lhs,
  output logic [W-1:0] alu_rhs,
  output logic [4:0]   alu_uop,
  input  logic [W-1:0] alu_out,
  input  logic [3:0]   alu_flags
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e       state_q;
  logic [W-1:0] acc_q;
  logic [W-1:0] mcand_q;
  logic [W-1:0] mplier_q;
  logic         carry_stk_q;
  logic         lost_stk_q;
  logic         mcand_lost_q;
  logic [W-1:0] result_q;
  logic         res_z_q;
  logic         res_n_q;
  logic         res_ovf_q;
  logic         busy_q;
  logic         done_q;

  logic         carry_stk_d;
  logic         lost_stk_d;
  logic         mcand_lost_d;
  logic [W-1:0] mplier_d;
  logic [W-1:0] mcand_d;

  // Only the carry flag is consumed; Z/N come from the final accumulator.
  logic unused_flags;
  assign unused_flags = ^{alu_flags[3:2], alu_flags[0]};

  // Sticky overflow terms and the shifted operands for the current iteration.
  always_comb begin
    carry_stk_d  = carry_stk_q | alu_flags[1];
    lost_stk_d   = lost_stk_q | (mplier_q[0] & mcand_lost_q);
    mcand_lost_d = mcand_lost_q | mcand_q[W-1];
    mcand_d      = mcand_q << 1;
    mplier_d     = mplier_q >> 1;
  end

  // ALU operands are driven only while iterating; otherwise the ALU sees a NOP.
  always_comb begin
    alu_uop = UOP_NOP;
    alu_lhs = '0;
    alu_rhs = '0;
    if (state_q == S_RUN) begin
      alu_uop = UOP_ADD;
      alu_lhs = acc_q;
      alu_rhs = mplier_q[0] ? mcand_q : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      carry_stk_q  <= 1'b0;
      lost_stk_q   <= 1'b0;
      mcand_lost_q <= 1'b0;
      result_q     <= '0;
      res_z_q      <= 1'b0;
      res_n_q      <= 1'b0;
      res_ovf_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            acc_q        <= '0;
            mcand_q      <= op_a;
            mplier_q     <= op_b;
            carry_stk_q  <= 1'b0;
            lost_stk_q   <= 1'b0;
            mcand_lost_q <= 1'b0;
            busy_q       <= 1'b1;
            if (op_b != '0) begin
              state_q <= S_RUN;
            end else begin
              // Zero multiplier: product is trivially zero, skip the ALU entirely.
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              result_q  <= '0;
              res_z_q   <= 1'b1;
              res_n_q   <= 1'b0;
              res_ovf_q <= 1'b0;
            end
          end
        end
        S_RUN: begin
          acc_q        <= alu_out;
          carry_stk_q  <= carry_stk_d;
          lost_stk_q   <= lost_stk_d;
          mcand_lost_q <= mcand_lost_d;
          mcand_q      <= mcand_d;
          mplier_q     <= mplier_d;
          if (mplier_d == '0) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            result_q  <= alu_out;
            res_z_q   <= (alu_out == '0);
            res_n_q   <= alu_out[W-1];
            res_ovf_q <= carry_stk_d | lost_stk_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign res_z   = res_z_q;
  assign res_n   = res_n_q;
  assign res_ovf = res_ovf_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural ADD-only ALU model.
`timescale 1ns/1ps
module tb_alu_mul_sequencer;

  localparam int unsigned W = 32;
  localparam logic [4:0] UOP_ADD = 5'b00001;
  localparam logic [4:0] UOP_NOP = 5'b00000;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] op_a, op_b;
  logic         busy, done, res_z, res_n, res_ovf;
  logic [W-1:0] result, alu_lhs, alu_rhs, alu_out;
  logic [4:0]   alu_uop;
  logic [3:0]   alu_flags;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // ALU model: 33-bit add exposes the carry; flags packed as [Z,N,C,V] with carry at bit 1.
  logic [W:0] alu_sum;
  always_comb begin
    alu_sum   = (alu_uop == UOP_ADD) ? ({1'b0, alu_lhs} + {1'b0, alu_rhs}) : '0;
    alu_out   = alu_sum[W-1:0];
    alu_flags = {(alu_sum[W-1:0] == '0), alu_sum[W-1], alu_sum[W], 1'b0};
  end

  alu_mul_sequencer #(.W(W), .UOP_ADD(UOP_ADD), .UOP_NOP(UOP_NOP)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .res_z(res_z), .res_n(res_n),
    .res_ovf(res_ovf), .alu_lhs(alu_lhs), .alu_rhs(alu_rhs), .alu_uop(alu_uop),
    .alu_out(alu_out), .alu_flags(alu_flags)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait for done after an accept edge; returns edges counted including the accept edge.
  task automatic wait_done(output int edges, output int adds);
    edges = 1;
    adds  = 0;
    while (!done && edges < 100) begin
      if (alu_uop == UOP_ADD) adds++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_res, input logic exp_z, input logic exp_n,
                         input logic exp_ovf, input int exp_edges);
    int edges, adds;
    @(negedge clk);
    op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op_a  = ~a;
    op_b  = ~b;
    wait_done(edges, adds);
    chk({tag, ".edges"}, 64'(edges), 64'(exp_edges));
    chk({tag, ".adds"}, 64'(adds), 64'(exp_edges - 1));
    chk({tag, ".done"}, 64'(done), 64'd1);
    chk({tag, ".busy"}, 64'(busy), 64'd1);
    chk({tag, ".result"}, 64'(result), 64'(exp_res));
    chk({tag, ".flags"}, 64'({res_z, res_n, res_ovf}), 64'({exp_z, exp_n, exp_ovf}));
    @(posedge clk); #1;
    chk({tag, ".done_clr"}, 64'({done, busy}), 64'd0);
    chk({tag, ".held"}, 64'(result), 64'(exp_res));
  endtask

  initial begin
    int edges, adds, cyc;
    logic saw_done;
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.outs", 64'({busy, done, res_z, res_n, res_ovf}), 64'd0);
    chk("rst.result", 64'(result), 64'd0);
    chk("rst.alu", 64'({alu_uop, alu_lhs, alu_rhs} != '0), 64'd0);
    @(negedge clk); rst = 1'b0;

    run_mul("3x5",      32'd3,          32'd5,          32'd15,         1'b0, 1'b0, 1'b0, 4);
    run_mul("bzero",    32'h0000_1234,  32'd0,          32'd0,          1'b1, 1'b0, 1'b0, 1);
    run_mul("lostbit",  32'h0001_0000,  32'h0001_0000,  32'd0,          1'b1, 1'b0, 1'b1, 18);
    run_mul("allones",  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  1'b0, 1'b0, 1'b1, 33);
    run_mul("msb",      32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0, 1'b1, 1'b0, 2);
    run_mul("carry",    32'h6000_0000,  32'd3,          32'h2000_0000,  1'b0, 1'b0, 1'b1, 3);
    run_mul("nooverflow", 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF,  1'b0, 1'b1, 1'b0, 18);

    // Start re-pulsed mid-RUN is ignored; a start held into the next IDLE is accepted.
    @(negedge clk);
    op_a = 32'd7; op_b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op_a = 32'd100; op_b = 32'd200;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0;
    while (!done && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("ign.done", 64'(done), 64'd1);
    chk("ign.result", 64'(result), 64'd63);
    start = 1'b1; op_a = 32'd2; op_b = 32'd3;
    @(posedge clk); #1;
    chk("ign.idle", 64'({busy, done}), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign.accept", 64'(busy), 64'd1);
    wait_done(edges, adds);
    chk("ign.edges2", 64'(edges), 64'd3);
    chk("ign.result2", 64'(result), 64'd6);
    @(posedge clk); #1;

    // Reset in the middle of a long multiply aborts it with no completion.
    @(negedge clk);
    op_a = 32'h0000_FFFF; op_b = 32'h0000_FFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid.busy_done", 64'({busy, done}), 64'd0);
    chk("rstmid.result", 64'(result), 64'd0);
    chk("rstmid.uop", 64'(alu_uop), 64'(UOP_NOP));
    chk("rstmid.lhs", 64'(alu_lhs), 64'd0);
    @(negedge clk); rst = 1'b0;
    saw_done = 1'b0;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("rstmid.no_done", 64'(saw_done), 64'd0);

    run_mul("post_rst", 32'd12, 32'd12, 32'd144, 1'b0, 1'b0, 1'b0, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
